// File: rtl/parameters_pkg.sv
// Shared constants and types for the SAR conversion sequencer.
// The optional comparator timeout is enabled with SAR_CTRL_TIMEOUT_EN.
package parameters_pkg;

  localparam int num_bits           = 8;
  localparam int SAMPLE_CYCLES_DEF  = 4;
  localparam int SETTLE_CYCLES_DEF  = 2;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } sar_state_t;

  // A phase of N cycles runs the down-counter from N-1 to zero.
  function automatic logic [7:0] wait_load(input int cycles);
    return (cycles <= 1) ? 8'd0 : 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/sar_conv_ctrl_if.sv
// Request/analog-front-end bundle of the SAR sequencer; slave = sequencer side.
// timeout_err is present only when SAR_CTRL_TIMEOUT_EN is defined.
interface sar_conv_ctrl_if #(
  parameter int NUM_BITS = parameters_pkg::num_bits
);
  logic                start;
  logic                comp_out;
  logic                comp_valid;
  logic                sample_en;
  logic                comp_strobe;
  logic [NUM_BITS-1:0] dac_code;
  logic [NUM_BITS-1:0] dout;
  logic                dout_valid;
  logic                ready;
  logic                overrun;
`ifdef SAR_CTRL_TIMEOUT_EN
  logic                timeout_err;
`endif

  modport master (
    output start, comp_out, comp_valid,
`ifdef SAR_CTRL_TIMEOUT_EN
    input  timeout_err,
`endif
    input  sample_en, comp_strobe, dac_code, dout, dout_valid, ready, overrun
  );

  modport slave (
    input  start, comp_out, comp_valid,
`ifdef SAR_CTRL_TIMEOUT_EN
    output timeout_err,
`endif
    output sample_en, comp_strobe, dac_code, dout, dout_valid, ready, overrun
  );

endinterface

// File: rtl/sar_ctrl_wait_cnt.sv
// 8-bit loadable down-counter with zero flag, shared by the sample,
// settle and comparator-timeout phases of the SAR sequencer.
module sar_ctrl_wait_cnt (
  input  logic       clk_1GHz,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_1GHz) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion sequencer: sample, MSB-to-LSB bit trials, one-cycle dout_valid.
// Define SAR_CTRL_TIMEOUT_EN to bound each comparator wait by TIMEOUT_CYCLES.
module sar_conv_ctrl
  import parameters_pkg::*;
#(
  parameter int NUM_BITS       = num_bits,
  parameter int SAMPLE_CYCLES  = SAMPLE_CYCLES_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic            clk_1GHz,
  input logic            reset,
  sar_conv_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BITS);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(NUM_BITS - 1);
  localparam logic [7:0]       SAMPLE_LOAD = wait_load(SAMPLE_CYCLES);
  localparam logic [7:0]       SETTLE_LOAD = wait_load(SETTLE_CYCLES);
  localparam logic [7:0]       TMO_LOAD    = wait_load(TIMEOUT_CYCLES);
  // With no settle time a new bit goes straight to its comparison.
  localparam sar_state_t       BIT_ENTRY   = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;

  function automatic logic [NUM_BITS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_BITS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  sar_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] code_q, code_d;
  logic [NUM_BITS-1:0] dout_q, dout_d;
  logic [NUM_BITS-1:0] resolved;
  logic                sample_en_q, sample_en_d;
  logic                comp_strobe_q, comp_strobe_d;
  logic                dout_valid_q, dout_valid_d;
  logic                ready_q, ready_d;
  logic                cnt_load;
  logic [7:0]          cnt_val;
  logic                cnt_zero;
  logic                in_cmp;
  logic                tmo_hit;
  logic                resolve;
  logic                enter_cmp;
`ifdef SAR_CTRL_TIMEOUT_EN
  logic                tmo_err_q, tmo_err_d;
`endif

  sar_ctrl_wait_cnt u_wait_cnt (
    .clk_1GHz   (clk_1GHz),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Bit decision: a real comparator answer wins over a same-cycle timeout.
  always_comb begin
    in_cmp = (state_q == COMPARE);
`ifdef SAR_CTRL_TIMEOUT_EN
    tmo_hit = in_cmp & cnt_zero & ~bus.comp_valid;
`else
    tmo_hit = 1'b0;
`endif
    resolve  = in_cmp & (bus.comp_valid | tmo_hit);
    resolved = (bus.comp_valid & bus.comp_out) ? code_q : (code_q & ~onehot(idx_q));
  end

  always_ff @(posedge clk_1GHz) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SAMPLE;
      SAMPLE:  if (cnt_zero) state_d = BIT_ENTRY;
      SETTLE:  if (cnt_zero) state_d = COMPARE;
      COMPARE: if (resolve) state_d = (idx_q != '0) ? BIT_ENTRY : DONE;
      DONE:    state_d = bus.start ? SAMPLE : IDLE;
      default: state_d = IDLE;
    endcase

    // COMPARE re-enters itself for the next bit when there is no settle phase.
    enter_cmp = (state_d == COMPARE) && (!in_cmp || resolve);

    // The timeout preload is harmless when the timeout build is off: nothing watches it.
    cnt_load = 1'b1;
    cnt_val  = TMO_LOAD;
    if (state_d == SAMPLE && state_q != SAMPLE) begin
      cnt_val = SAMPLE_LOAD;
    end else if (state_d == SETTLE && state_q != SETTLE) begin
      cnt_val = SETTLE_LOAD;
    end else if (!enter_cmp) begin
      cnt_load = 1'b0;
    end
  end

  always_comb begin
    sample_en_d   = (state_d == SAMPLE);
    comp_strobe_d = enter_cmp;
    dout_valid_d  = (state_d == DONE);
    ready_d       = (state_d == IDLE) || (state_d == DONE);
    code_d        = code_q;
    idx_d         = idx_q;
    dout_d        = dout_q;

    if (state_d == SAMPLE && state_q != SAMPLE) begin
      code_d = '0;
    end else if (state_q == SAMPLE && state_d != SAMPLE) begin
      code_d = onehot(MSB_IDX);
      idx_d  = MSB_IDX;
    end else if (resolve) begin
      if (idx_q != '0) begin
        code_d = resolved | onehot(idx_q - 1'b1);
        idx_d  = idx_q - 1'b1;
      end else begin
        dout_d = resolved;
      end
    end

`ifdef SAR_CTRL_TIMEOUT_EN
    tmo_err_d = tmo_err_q;
    if (bus.start && (state_q == IDLE || state_q == DONE)) tmo_err_d = 1'b0;
    if (tmo_hit) tmo_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_1GHz) begin
    if (reset) begin
      idx_q         <= '0;
      code_q        <= '0;
      dout_q        <= '0;
      sample_en_q   <= 1'b0;
      comp_strobe_q <= 1'b0;
      dout_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
`ifdef SAR_CTRL_TIMEOUT_EN
      tmo_err_q     <= 1'b0;
`endif
    end else begin
      idx_q         <= idx_d;
      code_q        <= code_d;
      dout_q        <= dout_d;
      sample_en_q   <= sample_en_d;
      comp_strobe_q <= comp_strobe_d;
      dout_valid_q  <= dout_valid_d;
      ready_q       <= ready_d;
`ifdef SAR_CTRL_TIMEOUT_EN
      tmo_err_q     <= tmo_err_d;
`endif
    end
  end

  assign bus.sample_en   = sample_en_q;
  assign bus.comp_strobe = comp_strobe_q;
  assign bus.dac_code    = code_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.ready       = ready_q;
  // Overrun flags the very cycle the rejected request is seen, so it is not delayed a clock.
  assign bus.overrun     = bus.start & ~ready_q & ~reset;
`ifdef SAR_CTRL_TIMEOUT_EN
  assign bus.timeout_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Self-checking bench for sar_conv_ctrl with a latency-configurable comparator model.
// Define SAR_CTRL_TIMEOUT_EN to also exercise the comparator timeout.
module tb_sar_conv_ctrl;

  localparam int N   = 8;
  localparam int SMP = 4;
  localparam int STL = 2;
  localparam int TMO = 16;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  logic       rsp_en;
  int         rsp_lat;
  logic [7:0] rsp_vin;
  int         pend;
  logic [7:0] trial_q[$];

  sar_conv_ctrl_if #(.NUM_BITS(N)) bus ();

  sar_conv_ctrl dut (
    .clk_1GHz (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: answers (vin >= dac_code) rsp_lat cycles after each strobe.
  initial begin
    bus.comp_valid = 1'b0;
    bus.comp_out   = 1'b0;
    pend           = -1;
    forever begin
      @(posedge clk);
      #1;
      bus.comp_valid = 1'b0;
      if (!rsp_en) begin
        pend = -1;
      end else begin
        if (bus.comp_strobe) pend = rsp_lat;
        if (pend == 0) begin
          bus.comp_valid = 1'b1;
          bus.comp_out   = (rsp_vin >= bus.dac_code);
          pend           = -1;
        end else if (pend > 0) begin
          pend = pend - 1;
        end
      end
    end
  end

  // Ideal result of a conversion is vin itself; trial k is vin's top k bits plus a one below.
  function automatic logic [7:0] exp_trial(input logic [7:0] vin, input int k);
    int hi;
    hi = (int'(vin) >> (8 - k)) << (8 - k);
    return 8'(hi | (8'h80 >> k));
  endfunction

  function automatic int exp_done_cycle(input int lat);
    return SMP + N * (STL + 1 + lat) + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic convert(input logic [7:0] vin, input int lat, output int dv_cyc,
                         output logic [7:0] dv_data, output int nstrobe, output int nsample);
    rsp_vin = vin;
    rsp_lat = lat;
    rsp_en  = 1'b1;
    trial_q.delete();
    nstrobe = 0;
    nsample = 0;
    dv_cyc  = -1;
    dv_data = 8'hxx;
    bus.start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      if (bus.sample_en) nsample++;
      if (bus.comp_strobe) begin
        nstrobe++;
        trial_q.push_back(bus.dac_code);
      end
      if (bus.dout_valid) begin
        dv_cyc  = c;
        dv_data = bus.dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    reset     = 1'b1;
    rsp_en    = 1'b0;
    rsp_lat   = 0;
    rsp_vin   = 8'h00;
    repeat (3) step();
    n_total++;
    if (bus.sample_en !== 1'b0) $display("FAIL reset_start_ignored sample_en=%b want 0", bus.sample_en);
    else n_pass++;
    bus.start = 1'b0;
    reset     = 1'b0;
    step();
    n_total++;
    if (bus.sample_en !== 1'b0) $display("FAIL reset_sample_en got %b want 0", bus.sample_en); else n_pass++;
    n_total++;
    if (bus.comp_strobe !== 1'b0) $display("FAIL reset_comp_strobe got %b want 0", bus.comp_strobe); else n_pass++;
    n_total++;
    if (bus.dac_code !== 8'h00) $display("FAIL reset_dac_code got %h want 00", bus.dac_code); else n_pass++;
    n_total++;
    if (bus.dout !== 8'h00) $display("FAIL reset_dout got %h want 00", bus.dout); else n_pass++;
    n_total++;
    if (bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid got %b want 0", bus.dout_valid); else n_pass++;
    n_total++;
    if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready); else n_pass++;
    n_total++;
    if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.overrun); else n_pass++;
`ifdef SAR_CTRL_TIMEOUT_EN
    n_total++;
    if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err got %b want 0", bus.timeout_err); else n_pass++;
`endif
  endtask

  task automatic test_all_ones();
    int cyc, ns, nsm;
    logic [7:0] d;
    convert(8'hFF, 0, cyc, d, ns, nsm);
    n_total++;
    if (d !== 8'hFF) $display("FAIL ones_dout got %h want ff", d); else n_pass++;
    n_total++;
    if (cyc != exp_done_cycle(0)) $display("FAIL ones_cycle got %0d want %0d", cyc, exp_done_cycle(0)); else n_pass++;
    n_total++;
    if (ns != N) $display("FAIL ones_strobes got %0d want %0d", ns, N); else n_pass++;
    n_total++;
    if (nsm != SMP) $display("FAIL ones_sample_cycles got %0d want %0d", nsm, SMP); else n_pass++;
    step();
    n_total++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hFF || bus.ready !== 1'b1)
      $display("FAIL ones_hold dv=%b dout=%h ready=%b want 0/ff/1", bus.dout_valid, bus.dout, bus.ready);
    else n_pass++;
  endtask

  task automatic test_a5_trials();
    int cyc, ns, nsm;
    logic [7:0] d;
    convert(8'hA5, 0, cyc, d, ns, nsm);
    n_total++;
    if (trial_q.size() != N) $display("FAIL a5_trial_count got %0d want %0d", trial_q.size(), N); else n_pass++;
    for (int k = 0; k < N && k < trial_q.size(); k++) begin
      n_total++;
      if (trial_q[k] !== exp_trial(8'hA5, k))
        $display("FAIL a5_trial%0d got %h want %h", k, trial_q[k], exp_trial(8'hA5, k));
      else n_pass++;
    end
    n_total++;
    if (d !== 8'hA5) $display("FAIL a5_dout got %h want a5", d); else n_pass++;
    step();
  endtask

  task automatic test_random();
    int cyc, ns, nsm, lat;
    logic [7:0] v, d;
    for (int i = 0; i < 6; i++) begin
      v   = 8'($urandom_range(0, 255));
      lat = int'($urandom_range(0, 2));
      convert(v, lat, cyc, d, ns, nsm);
      n_total++;
      if (d !== v) $display("FAIL rand%0d_dout got %h want %h", i, d, v); else n_pass++;
      n_total++;
      if (cyc != exp_done_cycle(lat))
        $display("FAIL rand%0d_cycle got %0d want %0d", i, cyc, exp_done_cycle(lat));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_latency3();
    int cyc, ns, nsm;
    logic [7:0] d;
    convert(8'h00, 3, cyc, d, ns, nsm);
    n_total++;
    if (d !== 8'h00) $display("FAIL lat3_dout got %h want 00", d); else n_pass++;
    n_total++;
    if (cyc != 53) $display("FAIL lat3_cycle got %0d want 53", cyc); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int period, dv_n, ovr_bad, rdy_bad;
    int dv_at[3];
    logic [7:0] dv_d[3];
    period  = exp_done_cycle(0);
    dv_n    = 0;
    ovr_bad = 0;
    rdy_bad = 0;
    rsp_vin = 8'($urandom_range(0, 255));
    rsp_lat = 0;
    rsp_en  = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 3 * period; c++) begin
      step();
      if (bus.overrun !== ((c % period) != 0)) ovr_bad++;
      if (bus.ready !== ((c % period) == 0)) rdy_bad++;
      if (bus.dout_valid === 1'b1 && dv_n < 3) begin
        dv_at[dv_n] = c;
        dv_d[dv_n]  = bus.dout;
        dv_n++;
      end
    end
    bus.start = 1'b0;
    n_total++;
    if (dv_n != 3) $display("FAIL b2b_count got %0d want 3", dv_n); else n_pass++;
    for (int i = 0; i < dv_n; i++) begin
      n_total++;
      if (dv_at[i] != (i + 1) * period || dv_d[i] !== rsp_vin)
        $display("FAIL b2b_conv%0d cycle=%0d dout=%h want cycle=%0d dout=%h",
                 i, dv_at[i], dv_d[i], (i + 1) * period, rsp_vin);
      else n_pass++;
    end
    n_total++;
    if (ovr_bad != 0) $display("FAIL b2b_overrun wrong in %0d cycles want 0", ovr_bad); else n_pass++;
    n_total++;
    if (rdy_bad != 0) $display("FAIL b2b_ready wrong in %0d cycles want 0", rdy_bad); else n_pass++;
    step();
    n_total++;
    if (bus.ready !== 1'b1 || bus.sample_en !== 1'b0)
      $display("FAIL b2b_idle ready=%b sample_en=%b want 1/0", bus.ready, bus.sample_en);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int strobes, cyc, ns, nsm;
    logic found;
    logic [7:0] v, d;
    rsp_vin = 8'h5C;
    rsp_lat = 0;
    rsp_en  = 1'b1;
    strobes = 0;
    found   = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.comp_strobe) strobes++;
      if (strobes == 4) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL midrst_4th_compare strobes=%0d want 4", strobes); else n_pass++;
    reset = 1'b1;
    step();
    n_total++;
    if (bus.dac_code !== 8'h00 || bus.ready !== 1'b1 || bus.dout_valid !== 1'b0)
      $display("FAIL midrst_outputs dac=%h ready=%b dv=%b want 00/1/0", bus.dac_code, bus.ready, bus.dout_valid);
    else n_pass++;
    n_total++;
    if (bus.dout !== 8'h00 || bus.sample_en !== 1'b0 || bus.comp_strobe !== 1'b0)
      $display("FAIL midrst_clear dout=%h sample_en=%b strobe=%b want 00/0/0", bus.dout, bus.sample_en, bus.comp_strobe);
    else n_pass++;
    reset = 1'b0;
    v = 8'($urandom_range(0, 255));
    convert(v, 0, cyc, d, ns, nsm);
    n_total++;
    if (d !== v || cyc != exp_done_cycle(0))
      $display("FAIL midrst_fresh dout=%h cycle=%0d want %h/%0d", d, cyc, v, exp_done_cycle(0));
    else n_pass++;
    step();
  endtask

`ifdef SAR_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, ns, nsm, want;
    logic [7:0] d;
    want = SMP + N * (STL + TMO) + 1;
    rsp_en = 1'b0;
    cyc = -1;
    d   = 8'hxx;
    bus.start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.dout_valid) begin
        cyc = c;
        d   = bus.dout;
        break;
      end
    end
    n_total++;
    if (cyc != want || d !== 8'h00) $display("FAIL tmo_done cycle=%0d dout=%h want %0d/00", cyc, d, want);
    else n_pass++;
    step();
    n_total++;
    if (bus.timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", bus.timeout_err); else n_pass++;
    convert(8'h3C, 0, cyc, d, ns, nsm);
    n_total++;
    if (bus.timeout_err !== 1'b0 || d !== 8'h3C)
      $display("FAIL tmo_clear err=%b dout=%h want 0/3c", bus.timeout_err, d);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    rsp_en    = 1'b0;
    rsp_lat   = 0;
    rsp_vin   = 8'h00;
    test_reset();
    test_all_ones();
    test_a5_trials();
    test_random();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
`ifdef SAR_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t want finish earlier", $time);
    $fatal(1, "bench time limit");
  end

endmodule
